csa_add3_unit: RTL and testbench
================================

Name: csa_add3_unit

Overview:
- Registered three-operand modular adder for the SHA-256 datapath: result = a + b + c mod 2^WIDTH.
- Stage one is a bitwise 3:2 carry-save compressor producing sum and carry vectors.
- Stage two is a ripple carry-propagate adder built from one-bit full-adder cells.
- Used wherever SHA-256 round logic sums three 32-bit words.

Parameters:
- WIDTH, 32, operand/result width in bits (must be >= 2).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  a/b/c sampled this cycle when high
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- c  input  WIDTH  operand C (drive 0 for plain two-operand add)
- csa_sum  output  WIDTH  registered compressor sum vector
- csa_carry  output  WIDTH  registered compressor carry vector
- result  output  WIDTH  registered (a+b+c) mod 2^WIDTH
- out_valid  output  1  result/csa_* valid this cycle

Behaviour:
- Compressor, per bit i:
  - s[i] = a[i]^b[i]^c[i]
  - m[i] = maj(a[i],b[i],c[i])
  - carry vector k = {m[WIDTH-2:0], 1'b0}; m[WIDTH-1] is discarded (mod 2^WIDTH).
- CPA: result = s + k mod 2^WIDTH.
  - Ripple chain of full-adder cells, carry-in of bit 0 = 0, final carry-out discarded.
- Invariant: s + k ≡ a + b + c (mod 2^WIDTH).
- Latency 1: in_valid sampled at edge N -> csa_sum, csa_carry, result, out_valid updated at edge N.
- out_valid is in_valid delayed one cycle.
- Data registers load only when in_valid=1 and hold otherwise; out_valid is always updated.
- No backpressure; a new operand set is accepted every cycle.
- Reset (async assert, sync-safe deassert): csa_sum = 0, csa_carry = 0, result = 0, out_valid = 0.
  - Reset mid-operation discards any in-flight operand.
- Wrap-around: all-ones operands, e.g. FFFFFFFF+FFFFFFFF+FFFFFFFF -> FFFFFFFD; no overflow flag.

Optional Feature:
- Macro CSA_PIPE_STAGE_EN.
- Defined: an extra register stage sits between compressor and CPA.
  - csa_sum/csa_carry appear at latency 1; result and out_valid at latency 2.
  - out_valid is in_valid delayed two cycles; both stages reset to 0.
- Undefined: single stage; everything appears at latency 1 as above.

Decomposition:
- Shared package sha_arith_pkg holds:
  - WORD_W = 32
  - typedef word_t (logic [WORD_W-1:0])
  - function maj3 for bitwise majority
- Sub-module onebit_fa_cell: inputs x, y, cin; outputs sum = x^y^cin, cout = maj(x,y,cin), and_o = x&y, or_o = x|y.
  - Instantiated WIDTH times for the CPA ripple chain; and_o/or_o are left unused at top level.

Test Plan:
- Cell exhaustive: onebit_fa_cell, all 8 {cin,y,x} combos -> e.g. 1,1,1 gives sum=1, cout=1, and_o=1, or_o=1; 0,1,0 gives sum=1, cout=0, and_o=0, or_o=1.
- Three-operand: a=a0ced587, b=aca69a1b, c=81fdd47d -> csa_sum=8D959BE1, csa_carry=41DDA83E, result=CF73441F one cycle later.
- Two-operand with c=0, back-to-back every cycle:
  - a0ced587+aca69a1b -> 4D756FA2
  - d6f28b79+449a9035 -> 1B8D1BAE
  - e2bb5641+1e0049d5 -> 00BBA016
  - 04361d9c+1023104d -> 14592DE9
  - One result per cycle, out_valid continuously high.
- Wrap: a=b=c=FFFFFFFF -> result=FFFFFFFD.
- Hold/reset:
  - in_valid=0 -> outputs hold and out_valid=0.
  - Assert rst_n=0 mid-stream -> all outputs 0 immediately (asynchronously); first result after release follows in_valid.
- With CSA_PIPE_STAGE_EN defined, repeat the three-operand case -> result CF73441F at latency 2, csa_* at latency 1.

Source files
------------

// File: rtl/sha_arith_pkg.sv
// Shared arithmetic definitions for the SHA-256 datapath adders.
package sha_arith_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    // Majority of three bits; applied bit by bit it gives the bitwise majority.
    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

endpackage

// File: rtl/onebit_fa_cell.sv
// One-bit full-adder cell used to build the ripple carry-propagate chain.
// The and_o/or_o (generate/propagate) terms are exported for carry-lookahead reuse.
module onebit_fa_cell
    import sha_arith_pkg::*;
(
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic sum,
    output logic cout,
    output logic and_o,
    output logic or_o
);

    assign sum   = x ^ y ^ cin;
    assign cout  = maj3(x, y, cin);
    assign and_o = x & y;
    assign or_o  = x | y;

endmodule

// File: rtl/csa_add3_unit.sv
// Registered three-operand modular adder: result = a + b + c mod 2^WIDTH.
// A 3:2 carry-save compressor feeds a ripple carry-propagate adder.
// Build option CSA_PIPE_STAGE_EN: registers the compressor outputs before the
// CPA, so csa_sum/csa_carry stay at latency 1 and result/out_valid move to 2.
module csa_add3_unit
    import sha_arith_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] csa_sum,
    output logic [WIDTH-1:0] csa_carry,
    output logic [WIDTH-1:0] result,
    output logic             out_valid
);

`ifdef CSA_PIPE_STAGE_EN
    localparam int STAGES = 2;
`else
    localparam int STAGES = 1;
`endif

    logic [WIDTH-1:0]  s_w, m_w, k_w;
    logic              maj_msb_unused;
    logic [WIDTH-1:0]  cpa_x, cpa_y, cpa_s;
    logic [WIDTH:0]    cy;
    logic              cout_unused;
    logic [WIDTH-1:0]  fa_and_unused, fa_or_unused;
    logic              res_load;

    logic [WIDTH-1:0]  csa_sum_q, csa_sum_d;
    logic [WIDTH-1:0]  csa_carry_q, csa_carry_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic [STAGES-1:0] vld_pipe_q, vld_pipe_d;

    // 3:2 compressor: per-bit xor sum and majority carry.
    always_comb begin
        s_w = '0;
        m_w = '0;
        for (int i = 0; i < WIDTH; i++) begin
            s_w[i] = a[i] ^ b[i] ^ c[i];
            m_w[i] = maj3(a[i], b[i], c[i]);
        end
    end

    // Carry vector is the majority shifted up; the top majority bit falls off (mod 2^WIDTH).
    assign k_w            = {m_w[WIDTH-2:0], 1'b0};
    assign maj_msb_unused = m_w[WIDTH-1];

`ifdef CSA_PIPE_STAGE_EN
    assign cpa_x    = csa_sum_q;
    assign cpa_y    = csa_carry_q;
    assign res_load = vld_pipe_q[0];
`else
    assign cpa_x    = s_w;
    assign cpa_y    = k_w;
    assign res_load = in_valid;
`endif

    // Ripple CPA: carry-in of bit 0 is zero, final carry-out is dropped.
    assign cy[0] = 1'b0;
    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        onebit_fa_cell u_fa (
            .x     (cpa_x[i]),
            .y     (cpa_y[i]),
            .cin   (cy[i]),
            .sum   (cpa_s[i]),
            .cout  (cy[i+1]),
            .and_o (fa_and_unused[i]),
            .or_o  (fa_or_unused[i])
        );
    end
    assign cout_unused = cy[WIDTH];

    // Next state: data registers load on their stage's valid, valid pipe always shifts.
    always_comb begin
        csa_sum_d   = in_valid ? s_w : csa_sum_q;
        csa_carry_d = in_valid ? k_w : csa_carry_q;
        result_d    = res_load ? cpa_s : result_q;
        vld_pipe_d  = STAGES'({vld_pipe_q, in_valid});
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csa_sum_q   <= '0;
            csa_carry_q <= '0;
            result_q    <= '0;
            vld_pipe_q  <= '0;
        end else begin
            csa_sum_q   <= csa_sum_d;
            csa_carry_q <= csa_carry_d;
            result_q    <= result_d;
            vld_pipe_q  <= vld_pipe_d;
        end
    end

    assign csa_sum   = csa_sum_q;
    assign csa_carry = csa_carry_q;
    assign result    = result_q;
    assign out_valid = vld_pipe_q[STAGES-1];

endmodule

// File: tb/tb_csa_add3_unit.sv
// Self-checking bench for csa_add3_unit (honours CSA_PIPE_STAGE_EN for latency).
module tb_csa_add3_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] a, b, c;
    logic [31:0] csa_sum, csa_carry, result;
    logic        out_valid;

    logic        cx, cyi, cc;
    logic        c_sum, c_cout, c_and, c_or;

    int npass = 0;
    int ntot  = 0;

    // Reference model state: what each output must show after the latest edge.
    logic [31:0] m_sum, m_carry, m_res, m_p1;
    logic        m_vld, m_vld1;

    csa_add3_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .c         (c),
        .csa_sum   (csa_sum),
        .csa_carry (csa_carry),
        .result    (result),
        .out_valid (out_valid)
    );

    onebit_fa_cell u_cell (
        .x     (cx),
        .y     (cyi),
        .cin   (cc),
        .sum   (c_sum),
        .cout  (c_cout),
        .and_o (c_and),
        .or_o  (c_or)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic model_clear();
        m_sum = '0; m_carry = '0; m_res = '0; m_p1 = '0; m_vld = 1'b0; m_vld1 = 1'b0;
    endtask

    // Drive one operand set, advance one edge, update the model, settle #1.
    task automatic step(input logic v, input logic [31:0] xa, input logic [31:0] xb,
                        input logic [31:0] xc);
        in_valid = v; a = xa; b = xb; c = xc;
        @(posedge clk);
`ifdef CSA_PIPE_STAGE_EN
        m_vld = m_vld1;
        if (m_vld1) m_res = m_p1;
        m_vld1 = v;
`else
        m_vld = v;
        if (v) m_res = xa + xb + xc;
`endif
        if (v) begin
            m_sum   = xa ^ xb ^ xc;
            m_carry = ((xa & xb) | (xa & xc) | (xb & xc)) << 1;
            m_p1    = xa + xb + xc;
        end
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".csa_sum"},   csa_sum,   m_sum);
        check({tag, ".csa_carry"}, csa_carry, m_carry);
        check({tag, ".result"},    result,    m_res);
        check({tag, ".out_valid"}, {31'b0, out_valid}, {31'b0, m_vld});
        check({tag, ".invariant"}, csa_sum + csa_carry, m_p1);
    endtask

    logic [31:0] va [4];
    logic [31:0] vb [4];
    logic [31:0] vr [4];

    initial begin
        int tot;
        va = '{32'ha0ced587, 32'hd6f28b79, 32'he2bb5641, 32'h04361d9c};
        vb = '{32'haca69a1b, 32'h449a9035, 32'h1e0049d5, 32'h1023104d};
        vr = '{32'h4d756fa2, 32'h1b8d1bae, 32'h00bba016, 32'h14592de9};

        // Full-adder cell, all eight input combinations.
        for (int i = 0; i < 8; i++) begin
            cx = i[0]; cyi = i[1]; cc = i[2];
            #1;
            tot = int'(cx) + int'(cyi) + int'(cc);
            check($sformatf("cell%0d.sum", i),  {31'b0, c_sum},  32'(tot % 2));
            check($sformatf("cell%0d.cout", i), {31'b0, c_cout}, 32'(tot >= 2));
            check($sformatf("cell%0d.and", i),  {31'b0, c_and},  32'(cx && cyi));
            check($sformatf("cell%0d.or", i),   {31'b0, c_or},   32'(cx || cyi));
        end

        // Reset state.
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; c = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_model("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_model("post_reset_idle");

        // Three-operand directed vector.
        step(1'b1, 32'ha0ced587, 32'haca69a1b, 32'h81fdd47d);
        check("add3.csa_sum",   csa_sum,   32'h8d959be1);
        check("add3.csa_carry", csa_carry, 32'h41dda83e);
`ifdef CSA_PIPE_STAGE_EN
        check("add3.out_valid_l1", {31'b0, out_valid}, 32'd0);
        step(1'b0, 32'h0, 32'h0, 32'h0);
`endif
        check("add3.result",    result,    32'hcf73441f);
        check("add3.out_valid", {31'b0, out_valid}, 32'd1);
        check_model("add3");

        // Two-operand, back-to-back.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, va[i], vb[i], 32'h0);
            check_model($sformatf("add2_%0d", i));
`ifdef CSA_PIPE_STAGE_EN
            if (i > 0) check($sformatf("add2_%0d.result", i - 1), result, vr[i-1]);
`else
            check($sformatf("add2_%0d.result", i), result, vr[i]);
`endif
            check($sformatf("add2_%0d.out_valid", i), {31'b0, out_valid}, 32'd1);
        end
`ifdef CSA_PIPE_STAGE_EN
        step(1'b0, 32'h0, 32'h0, 32'h0);
        check("add2_3.result", result, vr[3]);
`endif

        // Wrap-around.
        step(1'b1, 32'hffffffff, 32'hffffffff, 32'hffffffff);
`ifdef CSA_PIPE_STAGE_EN
        step(1'b0, 32'h0, 32'h0, 32'h0);
`endif
        check("wrap.result", result, 32'hfffffffd);
        check_model("wrap");

        // Hold while idle: garbage on the operand bus must not load.
        for (int i = 0; i < 3; i++) begin
            step(1'b0, $urandom, $urandom, $urandom);
            check_model($sformatf("hold%0d", i));
        end
        check("hold.result", result, 32'hfffffffd);

        // Asynchronous reset mid-stream.
        step(1'b1, 32'h12345678, 32'h9abcdef0, 32'h0f0f0f0f);
        step(1'b1, 32'h11111111, 32'h22222222, 32'h33333333);
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        check_model("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 32'h0, 32'h0, 32'h0);
        check_model("after_reset_idle");
        step(1'b1, 32'h00000001, 32'h00000002, 32'h00000003);
        check_model("after_reset_first");
        step(1'b0, 32'h0, 32'h0, 32'h0);
        check_model("after_reset_drain");

        // Randomized traffic against the model.
        for (int i = 0; i < 200; i++) begin
            step(($urandom_range(3, 0) != 0), $urandom, $urandom,
                 ($urandom_range(4, 0) == 0) ? 32'h0 : $urandom);
            check_model($sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
